// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit for the RV32I pipeline.
// Accepts one instruction from the EX/MEM slot when IDLE. Non-memory ops pass straight
// through to write-back. Loads and stores run a single transaction on the data-memory
// req/gnt/rvalid bus. Illegal funct3, misalignment and bus timeouts raise a one-cycle
// fault pulse with a sticky code.
module mem_stage_lsu #(
    parameter int unsigned DM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [4:0]  in_op,
    input  logic [2:0]  in_fun_3,
    input  logic [31:0] in_alu_out,
    input  logic [31:0] in_store_data,
    input  logic [4:0]  in_rd,
    input  logic        flush,
    output logic        in_ready,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_gnt,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        lsu_fault,
    output logic [1:0]  fault_code
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;

    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_FUNCT3   = 2'b10;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

    // Last counter value before the transaction is abandoned.
    localparam logic [9:0] TO_LAST = 10'(DM_TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        flushed_q, flushed_d;
    logic        is_load_q, is_load_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  rd_q, rd_d;

    logic        dm_req_q, dm_req_d;
    logic        dm_we_q, dm_we_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [3:0]  dm_be_q, dm_be_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        lsu_fault_q, lsu_fault_d;
    logic [1:0]  fault_code_q, fault_code_d;

    logic        is_ld, is_st, f3_ok, misal, timed_out;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] lane;
    logic [31:0] load_val;

    // Decode the incoming instruction: legality, alignment, byte enables and store lanes.
    always_comb begin
        is_ld = (in_op == OP_LOAD);
        is_st = (in_op == OP_STORE);
        f3_ok = 1'b0;
        if (is_ld) begin
            case (in_fun_3)
                3'd0, 3'd1, 3'd2, 3'd4, 3'd5: f3_ok = 1'b1;
                default:                      f3_ok = 1'b0;
            endcase
        end else if (is_st) begin
            f3_ok = (in_fun_3 <= 3'd2);
        end
        misal = ((in_fun_3[1:0] == 2'b01) && in_alu_out[0]) ||
                ((in_fun_3[1:0] == 2'b10) && (in_alu_out[1:0] != 2'b00));
        case (in_fun_3[1:0])
            2'b00: begin
                be_new    = 4'b0001 << in_alu_out[1:0];
                wdata_new = {4{in_store_data[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << in_alu_out[1:0];
                wdata_new = {2{in_store_data[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = in_store_data;
            end
        endcase
    end

    // Extract and extend the loaded lane using the offset latched at accept time.
    always_comb begin
        lane = dm_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'd0:    load_val = {{24{lane[7]}}, lane[7:0]};
            3'd1:    load_val = {{16{lane[15]}}, lane[15:0]};
            3'd4:    load_val = {24'd0, lane[7:0]};
            3'd5:    load_val = {16'd0, lane[15:0]};
            default: load_val = lane;
        endcase
    end

    // Counter keeps counting past TO_LAST on a late grant, so compare with >=.
    always_comb begin
        timed_out = (cnt_q >= TO_LAST);
    end

    // Next-state and registered-output logic for the IDLE/REQ/RESP transaction FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flushed_d    = flushed_q;
        is_load_d    = is_load_q;
        f3_d         = f3_q;
        off_d        = off_q;
        rd_d         = rd_q;
        dm_req_d     = dm_req_q;
        dm_we_d      = dm_we_q;
        dm_addr_d    = dm_addr_q;
        dm_be_d      = dm_be_q;
        dm_wdata_d   = dm_wdata_q;
        wb_valid_d   = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        lsu_fault_d  = 1'b0;
        fault_code_d = fault_code_q;

        case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    if (!is_ld && !is_st) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = in_alu_out;
                        wb_rd_d    = in_rd;
                    end else if (!f3_ok) begin
                        lsu_fault_d  = 1'b1;
                        fault_code_d = FAULT_FUNCT3;
                    end else if (misal) begin
                        lsu_fault_d  = 1'b1;
                        fault_code_d = FAULT_MISALIGN;
                    end else begin
                        state_d    = REQ;
                        cnt_d      = 10'd0;
                        flushed_d  = 1'b0;
                        is_load_d  = is_ld;
                        f3_d       = in_fun_3;
                        off_d      = in_alu_out[1:0];
                        rd_d       = in_rd;
                        dm_req_d   = 1'b1;
                        dm_we_d    = is_st;
                        dm_addr_d  = {in_alu_out[31:2], 2'b00};
                        dm_be_d    = be_new;
                        dm_wdata_d = wdata_new;
                    end
                end
            end
            REQ: begin
                flushed_d = flushed_q | flush;
                cnt_d     = cnt_q + 10'd1;
                if (dm_gnt) begin
                    // A granted request always runs to completion; flush only hides wb.
                    dm_req_d = 1'b0;
                    if (!is_load_q) begin
                        state_d = IDLE;
                    end else if (dm_rvalid) begin
                        state_d = IDLE;
                        if (!(flushed_q || flush)) begin
                            wb_valid_d = 1'b1;
                            wb_data_d  = load_val;
                            wb_rd_d    = rd_q;
                        end
                    end else begin
                        state_d = RESP;
                    end
                end else if (flush) begin
                    dm_req_d = 1'b0;
                    state_d  = IDLE;
                end else if (timed_out) begin
                    dm_req_d     = 1'b0;
                    state_d      = IDLE;
                    lsu_fault_d  = 1'b1;
                    fault_code_d = FAULT_TIMEOUT;
                end
            end
            RESP: begin
                flushed_d = flushed_q | flush;
                cnt_d     = cnt_q + 10'd1;
                if (dm_rvalid) begin
                    state_d = IDLE;
                    if (!(flushed_q || flush)) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = load_val;
                        wb_rd_d    = rd_q;
                    end
                end else if (timed_out) begin
                    // A hung bus is reported even for a flushed load.
                    state_d      = IDLE;
                    lsu_fault_d  = 1'b1;
                    fault_code_d = FAULT_TIMEOUT;
                end
            end
            default: begin
                state_d  = IDLE;
                dm_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; async reset clears every output at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= 10'd0;
            flushed_q    <= 1'b0;
            is_load_q    <= 1'b0;
            f3_q         <= 3'd0;
            off_q        <= 2'd0;
            rd_q         <= 5'd0;
            dm_req_q     <= 1'b0;
            dm_we_q      <= 1'b0;
            dm_addr_q    <= 32'd0;
            dm_be_q      <= 4'd0;
            dm_wdata_q   <= 32'd0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= 5'd0;
            wb_data_q    <= 32'd0;
            lsu_fault_q  <= 1'b0;
            fault_code_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flushed_q    <= flushed_d;
            is_load_q    <= is_load_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            rd_q         <= rd_d;
            dm_req_q     <= dm_req_d;
            dm_we_q      <= dm_we_d;
            dm_addr_q    <= dm_addr_d;
            dm_be_q      <= dm_be_d;
            dm_wdata_q   <= dm_wdata_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            lsu_fault_q  <= lsu_fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    // in_ready depends on state only, never on the memory-bus inputs.
    always_comb begin
        in_ready   = (state_q == IDLE);
        dm_req     = dm_req_q;
        dm_we      = dm_we_q;
        dm_addr    = dm_addr_q;
        dm_be      = dm_be_q;
        dm_wdata   = dm_wdata_q;
        wb_valid   = wb_valid_q;
        wb_rd      = wb_rd_q;
        wb_data    = wb_data_q;
        lsu_fault  = lsu_fault_q;
        fault_code = fault_code_q;
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios plus a randomized run,
// all compared every cycle against a transaction-level model of the unit.
module tb_mem_stage_lsu;

    localparam int unsigned T = 8;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [4:0]  in_op;
    logic [2:0]  in_fun_3;
    logic [31:0] in_alu_out;
    logic [31:0] in_store_data;
    logic [4:0]  in_rd;
    logic        flush;
    logic        in_ready;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        lsu_fault;
    logic [1:0]  fault_code;

    int total = 0;
    int bad   = 0;

    mem_stage_lsu #(.DM_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_op(in_op), .in_fun_3(in_fun_3),
        .in_alu_out(in_alu_out), .in_store_data(in_store_data), .in_rd(in_rd),
        .flush(flush), .in_ready(in_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .lsu_fault(lsu_fault), .fault_code(fault_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Model: one pending transaction record plus the expected visible outputs.
    bit          m_busy, m_granted, m_load, m_flushed;
    int          m_age;
    logic [2:0]  m_f3;
    logic [31:0] m_addr;
    logic [4:0]  m_rd;
    bit          e_req, e_we, e_wbv, e_fault;
    logic [31:0] e_addr, e_wdata, e_wbd;
    logic [3:0]  e_be;
    logic [4:0]  e_wbrd;
    logic [1:0]  e_code;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_busy = 0; m_granted = 0; m_load = 0; m_flushed = 0; m_age = 0;
        e_req = 0; e_we = 0; e_wbv = 0; e_fault = 0; e_code = 0;
        e_addr = 0; e_wdata = 0; e_wbd = 0; e_be = 0; e_wbrd = 0;
    endtask

    function automatic logic [31:0] bytes_mask(input int nb);
        return (nb >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    endfunction

    task automatic deliver();
        int nb;
        logic [31:0] v;
        nb = 1 << (m_f3 % 4);
        v = (dm_rdata >> (8 * (m_addr % 4))) & bytes_mask(nb);
        if (m_f3 < 4 && nb < 4 && v[8 * nb - 1]) v = v | ~bytes_mask(nb);
        m_busy = 0;
        if (!m_flushed) begin
            e_wbv = 1; e_wbd = v; e_wbrd = m_rd;
        end
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        int nb;
        bit ld, ok;
        logic [31:0] w;
        e_wbv = 0;
        e_fault = 0;
        if (!m_busy) begin
            if (in_valid && !flush) begin
                if (in_op != 5'b00000 && in_op != 5'b01000) begin
                    e_wbv = 1; e_wbd = in_alu_out; e_wbrd = in_rd;
                end else begin
                    ld = (in_op == 5'b00000);
                    ok = ld ? (in_fun_3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (in_fun_3 <= 2);
                    nb = 1 << (in_fun_3 % 4);
                    if (!ok) begin
                        e_fault = 1; e_code = 2'b10;
                    end else if (in_alu_out % nb != 0) begin
                        e_fault = 1; e_code = 2'b01;
                    end else begin
                        m_busy = 1; m_granted = 0; m_age = 0; m_load = ld; m_flushed = 0;
                        m_f3 = in_fun_3; m_addr = in_alu_out; m_rd = in_rd;
                        e_req = 1; e_we = !ld;
                        e_addr = in_alu_out - (in_alu_out % 4);
                        e_be = 4'(((1 << nb) - 1) << (in_alu_out % 4));
                        w = in_store_data & bytes_mask(nb);
                        e_wdata = (nb == 1) ? w * 32'h0101_0101 :
                                  (nb == 2) ? w * 32'h0001_0001 : w;
                    end
                end
            end
        end else begin
            m_flushed = m_flushed | flush;
            if (!m_granted && dm_gnt) begin
                e_req = 0;
                if (!m_load) m_busy = 0;
                else if (dm_rvalid) deliver();
                else begin
                    m_granted = 1; m_age++;
                end
            end else if (!m_granted && flush) begin
                e_req = 0; m_busy = 0;
            end else if (m_granted && dm_rvalid) begin
                deliver();
            end else if (m_age >= int'(T) - 1) begin
                e_req = 0; m_busy = 0; e_fault = 1; e_code = 2'b11;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic cmp_all();
        chk("in_ready", in_ready, !m_busy);
        chk("dm_req", dm_req, e_req);
        if (e_req) begin
            chk("dm_we", dm_we, e_we);
            chk("dm_addr", dm_addr, e_addr);
            chk("dm_be", dm_be, e_be);
            chk("dm_wdata", dm_wdata, e_wdata);
        end
        chk("wb_valid", wb_valid, e_wbv);
        if (e_wbv) begin
            chk("wb_rd", wb_rd, e_wbrd);
            chk("wb_data", wb_data, e_wbd);
        end
        chk("lsu_fault", lsu_fault, e_fault);
        chk("fault_code", fault_code, e_code);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cmp_all();
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_op = 5'b01100; in_fun_3 = 0; in_alu_out = 0;
        in_store_data = 0; in_rd = 0; flush = 0;
        dm_gnt = 0; dm_rvalid = 0; dm_rdata = 0;
    endtask

    task automatic issue(input logic [4:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] rd);
        in_valid = 1; in_op = op; in_fun_3 = f3; in_alu_out = a; in_store_data = d; in_rd = rd;
    endtask

    int n;
    bit mood;

    initial begin
        idle_inputs();
        m_reset();
        rst = 0;
        #12;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_dm_req", dm_req, 0);
        @(negedge clk);
        rst = 1;
        cycle();
        chk("idle_fault_code", fault_code, 0);

        // Pass-through, then a second one back to back.
        issue(5'b01100, 3'd0, 32'd17, 32'd0, 5'd5);
        cycle();
        chk("pt_wb_valid", wb_valid, 1);
        chk("pt_wb_data", wb_data, 32'd17);
        chk("pt_wb_rd", wb_rd, 5'd5);
        chk("pt_in_ready", in_ready, 1);
        issue(5'b00100, 3'd0, 32'hDEAD_BEEF, 32'd0, 5'd9);
        cycle();
        chk("pt2_wb_data", wb_data, 32'hDEAD_BEEF);
        in_valid = 0;

        // SB to 0x103, grant after two wait cycles.
        issue(5'b01000, 3'd0, 32'h103, 32'h0000_00A5, 5'd0);
        cycle();
        in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            chk("sb_dm_req", dm_req, 1);
            chk("sb_dm_addr", dm_addr, 32'h100);
            chk("sb_dm_be", dm_be, 4'b1000);
            chk("sb_dm_wdata", dm_wdata, 32'hA5A5_A5A5);
            dm_gnt = (i == 2);
            cycle();
        end
        chk("sb_done_req", dm_req, 0);
        chk("sb_no_wb", wb_valid, 0);
        chk("sb_ready", in_ready, 1);
        dm_gnt = 0;

        // LB / LBU from 0x202 with data one cycle after grant.
        for (int k = 0; k < 2; k++) begin
            issue(5'b00000, (k == 0) ? 3'd0 : 3'd4, 32'h202, 32'd0, 5'd7);
            dm_gnt = 1;
            cycle();
            in_valid = 0;
            cycle();
            chk("lb_resp_req", dm_req, 0);
            dm_gnt = 0; dm_rvalid = 1; dm_rdata = 32'h0080_0000;
            cycle();
            chk("lb_model", e_wbd, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
            chk("lb_wb_data", wb_data, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
            chk("lb_wb_valid", wb_valid, 1);
            dm_rvalid = 0;
        end

        // Misaligned LW, then illegal load funct3.
        issue(5'b00000, 3'd2, 32'h206, 32'd0, 5'd1);
        cycle();
        chk("mis_fault", lsu_fault, 1);
        chk("mis_code", fault_code, 2'b01);
        chk("mis_req", dm_req, 0);
        issue(5'b00000, 3'd3, 32'h200, 32'd0, 5'd1);
        cycle();
        chk("f3_code", fault_code, 2'b10);
        chk("f3_model", e_code, 2'b10);
        in_valid = 0;
        cycle();
        chk("fault_pulse", lsu_fault, 0);

        // Timeout with no grant.
        issue(5'b00000, 3'd2, 32'h300, 32'd0, 5'd2);
        cycle();
        in_valid = 0;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (!dm_req) break;
            n++;
        end
        chk("to_req_cycles", n, T);
        chk("to_code", fault_code, 2'b11);
        chk("to_ready", in_ready, 1);

        // Flush while waiting for load data.
        issue(5'b00000, 3'd2, 32'h400, 32'd0, 5'd3);
        cycle();
        in_valid = 0; dm_gnt = 1;
        cycle();
        dm_gnt = 0; flush = 1;
        cycle();
        flush = 0; dm_rvalid = 1; dm_rdata = 32'h1234_5678;
        cycle();
        chk("flush_no_wb", wb_valid, 0);
        chk("flush_ready", in_ready, 1);
        dm_rvalid = 0;

        // Async reset in REQ, then a stray rvalid.
        issue(5'b00000, 3'd2, 32'h500, 32'd0, 5'd4);
        cycle();
        in_valid = 0;
        chk("rst_pre_req", dm_req, 1);
        #2 rst = 0;
        #1;
        chk("rst_req_drop", dm_req, 0);
        chk("rst_ready", in_ready, 1);
        m_reset();
        dm_rvalid = 1; dm_rdata = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        cycle();
        chk("rst_stray_wb", wb_valid, 0);
        dm_rvalid = 0;

        // Randomized traffic.
        mood = 1;
        for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) mood = ($urandom_range(0, 3) != 0);
            in_valid = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0, 1: in_op = 5'b00000;
                2: in_op = 5'b01000;
                default: in_op = 5'($urandom);
            endcase
            in_fun_3 = 3'($urandom);
            in_alu_out = $urandom;
            if ($urandom_range(0, 1) == 1) in_alu_out[1:0] = 2'b00;
            in_store_data = $urandom;
            in_rd = 5'($urandom);
            flush = ($urandom_range(0, 15) == 0);
            dm_gnt = mood ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
            dm_rvalid = ($urandom_range(0, 4) < 2);
            dm_rdata = $urandom;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-stage load/store unit of the RV32I pipeline, directly downstream of the EX-stage ALU. It takes the registered ALU result as the effective address or pass-through value, along with store data and decode fields. It drives a single-port data-memory request/grant/response bus and produces the write-back result for loads and non-memory ops. It stalls the pipeline while a memory transaction is outstanding.

## Interface
- DM_TIMEOUT, 255: max cycles in REQ+RESP before a timeout fault (1..1023)
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- in_valid  input  1  EX/MEM slot holds an instruction
- in_op  input  5  opcode[6:2]; LOAD=5'b00000, STORE=5'b01000, other = pass-through
- in_fun_3  input  3  funct3 (width/sign)
- in_alu_out  input  32  ALU result (address or result)
- in_store_data  input  32  rs2 value
- in_rd  input  5  destination register
- flush  input  1  kill the current/pending instruction
- in_ready  output  1  high only in IDLE; an instruction is accepted when in_valid && in_ready && !flush
- dm_req  output  1  memory request
- dm_we  output  1  1=store
- dm_addr  output  32  word address, bits[1:0]=0
- dm_be  output  4  byte enables
- dm_wdata  output  32  lane-replicated store data
- dm_gnt  input  1  request accepted
- dm_rvalid  input  1  load data valid
- dm_rdata  input  32  load word
- wb_valid  output  1  write-back pulse
- wb_rd  output  5  write-back register
- wb_data  output  32  write-back value
- lsu_fault  output  1  one-cycle fault pulse
- fault_code  output  2  01 misaligned, 10 illegal funct3, 11 timeout

## Operation
- FSM states: IDLE, REQ, RESP. Reset→IDLE. All registered outputs reset to 0. in_ready=1 during reset.
- Pass-through (IDLE, accepted, op not LOAD/STORE):
  - Next edge: wb_valid=1, wb_data=in_alu_out, wb_rd=in_rd.
  - Stay in IDLE.
- Legal funct3:
  - Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
  - Stores: 0 SB, 1 SH, 2 SW.
  - Any other value → fault 10, no request, no wb.
- Misaligned access: H with addr[0]=1, W with addr[1:0]≠0 → fault 01, no request, no wb. Illegal funct3 takes priority over misaligned.
- Memory op accepted (IDLE→REQ):
  - dm_req=1, dm_addr={addr[31:2],2'b00}, dm_we per op.
  - dm_be: SB 4'b0001<<a[1:0], SH 4'b0011<<a[1:0], SW 4'b1111. Loads also drive dm_be.
  - dm_wdata: SB {4{d[7:0]}}, SH {2{d[15:0]}}, SW d.
  - All dm_* outputs are held stable until dm_gnt is sampled high.
- REQ with dm_gnt:
  - Store → IDLE, dm_req=0, no wb.
  - Load with dm_rvalid in the same cycle → complete directly to IDLE.
  - Load otherwise → RESP, dm_req=0.
- RESP with dm_rvalid → IDLE. Load result:
  - Select the byte/half lane using the latched addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - wb_valid=1 on the next edge.
- Timeout:
  - A 10-bit counter clears on entry to REQ and increments each cycle in REQ/RESP.
  - When it equals DM_TIMEOUT-1 without completion: → IDLE, dm_req=0, fault 11, no wb.
- flush:
  - In IDLE: in_valid is ignored.
  - In REQ before gnt: dm_req drops next edge, → IDLE.
  - In REQ on the gnt cycle, or in RESP: transaction completes normally but wb_valid is suppressed. Remember flush in a sticky bit until IDLE.
- wb_valid and lsu_fault are single-cycle pulses. fault_code holds its last value until the next fault.
- Asynchronous reset mid-transaction: dm_req and all other outputs go to 0 immediately, state→IDLE. A later dm_rvalid is ignored.

## Timing
- Accept edge k: pass-through/fault outputs valid at k+1; dm_req first high at k+1.
- Zero-wait load (gnt and rvalid high at k+1): wb_valid at k+2. in_ready=1 from k+2.
- Store with gnt at k+1: in_ready=1 from k+2.
- Each gnt/rvalid wait cycle adds one cycle.
- in_ready is combinational from state only. There is no combinational path from dm_* inputs to in_ready.
- Back-to-back pass-through ops: one per cycle.

## Test plan
- Pass-through: op=5'b01100, alu_out=32'd17, rd=5 → next cycle wb_valid=1, wb_data=17, wb_rd=5; in_ready stays 1.
- SB addr=0x103, data=0x000000A5, gnt after 2 cycles → dm_addr=0x100, dm_be=4'b1000, dm_wdata=0xA5A5A5A5, held 3 cycles; no wb.
- LB addr=0x202, rdata=0x00800000, rvalid 1 cycle after gnt → wb_data=0xFFFFFF80. The same access as LBU → 0x00000080.
- LW addr=0x206 → lsu_fault=1, fault_code=01, dm_req never asserts. Load funct3=3 → fault_code=10.
- DM_TIMEOUT=8, load with gnt never asserted → dm_req drops after 8 cycles, fault_code=11, in_ready=1.
- flush during RESP, then rvalid → no wb_valid. Reset asserted in REQ → dm_req=0 at once, and a stray rvalid produces no wb.
